// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder: access sizes,
// FSM states, store lane enables/alignment and load extraction.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Reserved size 2'b11 is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      SIZE_B:  r = 1'b0;
      SIZE_H:  r = off[0];
      SIZE_W:  r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      SIZE_B:  r = 4'b0001 << off;
      SIZE_H:  r = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate right-aligned store data so every lane carries the right bits.
  function automatic logic [31:0] store_align(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      SIZE_B:  r = {4{wdata[7:0]}};
      SIZE_H:  r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = {{24{~uns & b[7]}}, b};
      SIZE_H:  r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port DEPTH_WORDS x 32 synchronous RAM with byte write enables and a
// registered read port. Contents are never reset.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-before-write: a store's read data is discarded by the responder.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store slave for the RV32 MEM stage: one access at a time, one-cycle
// ready pulse. Define DMEM_WAIT_EN to add WAIT_CYCLES wait states per access.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state, state_nx;
  logic        accept;
  logic        wait_done;
  logic        h_we;
  logic [1:0]  h_size;
  logic        h_uns;
  logic [1:0]  h_off;
  logic        mis_q;
  logic        a_we;
  logic [1:0]  a_size;
  logic [1:0]  a_off;
  logic [AW-1:0] a_idx;
  logic [31:0] a_wdata;
  logic        a_mis;
  logic        access_go;
  logic [31:0] bank_q;
  logic        unused_addr;

  assign unused_addr = &{1'b0, addr_i[31:AW+2]};
  assign accept      = (state == ST_IDLE) && req_i;

  always_ff @(posedge clk) begin
    if (accept) begin
      h_we   <= we_i;
      h_size <= size_i;
      h_uns  <= unsigned_i;
      h_off  <= addr_i[1:0];
    end
  end

`ifdef DMEM_WAIT_EN
  logic [3:0]    wait_cnt;
  logic [AW-1:0] h_idx;
  logic [31:0]   h_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      h_idx   <= addr_i[AW+1:2];
      h_wdata <= wdata_i;
    end
  end

  assign wait_done = (wait_cnt == 4'd1);
  // The RAM is touched on the WAIT->RESP edge, so it works from held fields.
  assign a_we      = h_we;
  assign a_size    = h_size;
  assign a_off     = h_off;
  assign a_idx     = h_idx;
  assign a_wdata   = h_wdata;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  assign wait_done = 1'b1;
  // The RAM is touched on the accept edge itself, so it works from the inputs.
  assign a_we      = we_i;
  assign a_size    = size_i;
  assign a_off     = addr_i[1:0];
  assign a_idx     = addr_i[AW+1:2];
  assign a_wdata   = wdata_i;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req_i) begin
`ifdef DMEM_WAIT_EN
          state_nx = ST_WAIT;
`else
          state_nx = ST_RESP;
`endif
        end
      end
      ST_WAIT: if (wait_done) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A reset in WAIT blocks the pending write because access_go is masked.
  assign a_mis     = is_misaligned(a_size, a_off);
  assign access_go = (state_nx == ST_RESP) && (state != ST_RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst)            mis_q <= 1'b0;
    else if (access_go) mis_q <= a_mis;
  end

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .en    (access_go),
    .we    ((a_we && !a_mis) ? lane_en(a_size, a_off) : 4'b0000),
    .addr  (a_idx),
    .wdata (store_align(a_wdata, a_size)),
    .rdata (bank_q)
  );

  assign ready_o    = (state == ST_RESP);
  assign busy_o     = (state != ST_IDLE);
  assign misalign_o = ready_o && mis_q;
  assign rdata_o    = (ready_o && !mis_q && !h_we)
                      ? load_extract(bank_q, h_size, h_off, h_uns) : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a byte-array
// reference model; works with or without DMEM_WAIT_EN.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          WAITC = 3;
  localparam int unsigned MEMB  = DEPTH * 4;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WAITC + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        busy_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [MEMB];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int unsigned base;
    n = nbytes(sz);
    base = a % MEMB;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned base;
    base = a % MEMB;
    for (int i = 0; i < nbytes(sz); i++) ref_mem[base + i] = 8'(wd >> (8 * i));
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic        e_mis;
    logic [31:0] e_rd;
    e_mis = ref_mis(sz, a);
    e_rd  = (e_mis || we) ? 32'd0 : ref_load(sz, uns, a);
    if (we && !e_mis) ref_store(sz, a, wd);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'($urandom); size_i = 2'($urandom); unsigned_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    rd = 32'd0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("busy_in_flight", busy_o, 1'b1);
      chk("ready_timing", ready_o, k == LAT);
      if (k == LAT) begin
        chk("rdata", rdata_o, e_rd);
        chk("misalign", misalign_o, e_mis);
        rd = rdata_o;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy_after", busy_o, 1'b0);
    chk("ready_after", ready_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // Word store interrupted by reset either in RESP (committed) or WAIT (dropped).
  task automatic rst_mid(input logic [31:0] a, input logic [31:0] wd, input bit in_resp);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0;
    if (in_resp) repeat (LAT - 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_misalign", misalign_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'd0);
    if (in_resp) ref_store(2'b10, a, wd);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] hold_addr [16];
    int pulses;
    int exp_pulses;
    logic exp_r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_ready", ready_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_misalign", misalign_o, 1'b0);
    @(posedge clk); #1;

    for (int w = 0; w < DEPTH; w++) do_access(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, rd);

    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);

    do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, rd);
    do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd);
    chk("lb_signed", rd, 32'hFFFFFF80);
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd);
    chk("lbu", rd, 32'h00000080);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    chk("lw_after_sb", rd, 32'h80ADBEEF);

    do_access(1'b1, 2'b10, 1'b0, 32'h14, 32'hAAAAAAAA, rd);
    do_access(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234, rd);
    do_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    chk("lw_after_sh", rd, 32'h1234AAAA);
    do_access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd);
    chk("lh", rd, 32'h00001234);

    do_access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rd);
    do_access(1'b1, 2'b01, 1'b0, 32'h15, 32'hFFFF, rd);
    do_access(1'b1, 2'b11, 1'b0, 32'h14, 32'h5555_5555, rd);
    do_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    chk("word_unchanged", rd, 32'h1234AAAA);

    do_access(1'b1, 2'b10, 1'b0, MEMB, 32'hC0FFEE11, rd);
    do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd);
    chk("alias_zero", rd, 32'hC0FFEE11);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      do_access(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
    end

    rst_mid(32'h20, 32'h0BADF00D, 1'b1);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    chk("rst_resp_committed", rd, 32'h0BADF00D);
`ifdef DMEM_WAIT_EN
    rst_mid(32'h20, 32'h12345678, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    chk("rst_wait_dropped", rd, 32'h0BADF00D);
`endif

    pulses = 0;
    exp_pulses = 0;
    for (int c = 0; c <= 6 + LAT; c++) begin
      hold_addr[c] = 32'($urandom_range(0, DEPTH - 1) * 4);
      req_i = (c < 6); we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = hold_addr[c];
      exp_r = (c >= LAT) && (((c - LAT) % (LAT + 1)) == 0) && ((c - LAT) < 6);
      @(negedge clk);
      chk("hold_ready", ready_o, exp_r);
      if (ready_o) pulses++;
      if (exp_r) begin
        exp_pulses++;
        chk("hold_rdata", rdata_o, ref_load(2'b10, 1'b0, hold_addr[c - LAT]));
      end
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    chk("hold_pulse_count", pulses, exp_pulses);
`ifndef DMEM_WAIT_EN
    chk("hold_three_pulses", pulses, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
